// File: rtl/flipflop_bank.sv
// WIDTH-bit register bank: per-bit hold/clear/toggle/set cells plus a global
// opcode for load, shift, rotate and increment/decrement, with edge/carry/zero flags.

module flipflop_bit_cell (
    input  logic i_q,
    input  logic i_b1,
    input  logic i_b2,
    output logic o_qn
);
    // {b1,b2}: 00 hold, 01 clear, 10 toggle, 11 set
    assign o_qn = (~i_q & i_b1) | (i_b1 & i_b2) | (i_q & ~i_b1 & ~i_b2);
endmodule

module flipflop_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             carry,
    output logic             zero
);
    typedef enum logic [2:0] {
        OP_BIT  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_ROTL = 3'b110,
        OP_ROTR = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_carry;

    logic [WIDTH-1:0] w_bit_qn;
    logic [WIDTH-1:0] w_qn;
    logic             w_carry;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            flipflop_bit_cell u_cell (
                .i_q  (r_q[gi]),
                .i_b1 (b1[gi]),
                .i_b2 (b2[gi]),
                .o_qn (w_bit_qn[gi])
            );
        end
    endgenerate

    // Each arm reads only the inputs its op owns, so X on the others stays out of q.
    always_comb begin
        w_qn    = r_q;
        w_carry = 1'b0;
        case (op_e'(op))
            OP_BIT:  w_qn = w_bit_qn;
            OP_LOAD: w_qn = d;
            OP_SHL: begin
                w_qn    = {r_q[WIDTH-2:0], ser_in};
                w_carry = r_q[WIDTH-1];
            end
            OP_SHR: begin
                w_qn    = {ser_in, r_q[WIDTH-1:1]};
                w_carry = r_q[0];
            end
            OP_INC: begin
                w_qn    = r_q + 1'b1;
                w_carry = &r_q;
            end
            OP_DEC: begin
                w_qn    = r_q - 1'b1;
                w_carry = ~|r_q;
            end
            OP_ROTL: begin
                w_qn    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_carry = r_q[WIDTH-1];
            end
            OP_ROTR: begin
                w_qn    = {r_q[0], r_q[WIDTH-1:1]};
                w_carry = r_q[0];
            end
            default: begin
                w_qn    = r_q;
                w_carry = 1'b0;
            end
        endcase
    end

    // Flags are one-cycle pulses: anything other than an enabled update clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= RESET_VALUE;
            r_rise  <= '0;
            r_fall  <= '0;
            r_carry <= 1'b0;
        end else if (en) begin
            r_q     <= w_qn;
            r_rise  <= w_qn & ~r_q;
            r_fall  <= ~w_qn & r_q;
            r_carry <= w_carry;
        end else begin
            r_rise  <= '0;
            r_fall  <= '0;
            r_carry <= 1'b0;
        end
    end

    assign q     = r_q;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign carry = r_carry;
    assign zero  = ~|r_q;
endmodule

// File: tb/tb_flipflop_bank.sv
// Directed-vector bench for flipflop_bank at WIDTH=4, RESET_VALUE=4'hA.

module tb_flipflop_bank;
    localparam int W = 4;

    localparam logic [2:0] BIT  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] INC  = 3'b100;
    localparam logic [2:0] DEC  = 3'b101;
    localparam logic [2:0] ROTL = 3'b110;
    localparam logic [2:0] ROTR = 3'b111;

    logic         clk = 1'b0;
    logic         rst, en, ser_in;
    logic [2:0]   op;
    logic [W-1:0] b1, b2, d;
    logic [W-1:0] q, rise, fall;
    logic         carry, zero;

    int n_chk = 0;
    int n_err = 0;

    flipflop_bank #(.WIDTH(W), .RESET_VALUE(4'hA)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .b1(b1), .b2(b2), .d(d),
        .ser_in(ser_in), .q(q), .rise(rise), .fall(fall), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample just after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] o,
                        input logic [W-1:0] vb1, input logic [W-1:0] vb2,
                        input logic [W-1:0] vd, input logic s);
        rst = r; en = e; op = o; b1 = vb1; b2 = vb2; d = vd; ser_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic [W-1:0] ef, input logic ec);
        chk({tag, ".q"},     32'(q),     32'(eq));
        chk({tag, ".rise"},  32'(rise),  32'(er));
        chk({tag, ".fall"},  32'(fall),  32'(ef));
        chk({tag, ".carry"}, 32'(carry), 32'(ec));
        chk({tag, ".zero"},  32'(zero),  32'(eq == '0));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; op = BIT; b1 = '0; b2 = '0; d = '0; ser_in = 1'b0;
        #2;

        step(1, 1, INC, 0, 0, 0, 0);
        chk_all("reset", 4'b1010, 0, 0, 0);

        step(0, 1, BIT, 4'b1111, 4'b0101, 0, 0);
        chk_all("bit_ts", 4'b0101, 4'b0101, 4'b1010, 0);
        step(0, 1, BIT, 4'b0000, 4'b1111, 0, 0);
        chk_all("bit_clr", 4'b0000, 0, 4'b0101, 0);
        step(0, 1, BIT, 4'b0000, 4'b0000, 4'b1111, 1);
        chk_all("bit_hold", 4'b0000, 0, 0, 0);

        step(0, 1, LOAD, 4'b1111, 4'b1111, 4'b1111, 0);
        chk_all("load_f", 4'b1111, 4'b1111, 0, 0);
        step(0, 1, INC, 4'b1111, 4'b0000, 0, 1);
        chk_all("inc_wrap", 4'b0000, 0, 4'b1111, 1);
        step(0, 1, DEC, 0, 0, 0, 0);
        chk_all("dec_wrap", 4'b1111, 4'b1111, 0, 1);
        step(0, 1, DEC, 0, 0, 0, 0);
        chk_all("dec", 4'b1110, 0, 4'b0001, 0);

        step(0, 1, LOAD, 0, 0, 4'b1001, 0);
        chk_all("load_9", 4'b1001, 4'b0001, 4'b0110, 0);
        step(0, 1, SHL, 0, 0, 4'b1111, 0);
        chk_all("shl", 4'b0010, 4'b0010, 4'b1001, 1);
        step(0, 1, SHR, 0, 0, 0, 1);
        chk_all("shr", 4'b1001, 4'b1001, 4'b0010, 0);
        step(0, 1, ROTR, 0, 0, 0, 0);
        chk_all("rotr", 4'b1100, 4'b0100, 4'b0001, 1);
        step(0, 1, ROTL, 0, 0, 0, 0);
        chk_all("rotl", 4'b1001, 4'b0001, 4'b0100, 1);

        step(0, 1, LOAD, 0, 0, 4'b0110, 0);
        chk_all("load_6", 4'b0110, 4'b0110, 4'b1001, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, LOAD, 0, 0, 4'b1111, 1);
            chk_all($sformatf("en_off%0d", i), 4'b0110, 0, 0, 0);
        end

        step(0, 1, LOAD, 0, 0, 4'b0000, 0);
        chk_all("load_0", 4'b0000, 0, 4'b0110, 0);
        step(0, 1, INC, 0, 0, 0, 0);
        chk_all("inc1", 4'b0001, 4'b0001, 0, 0);
        step(0, 1, INC, 0, 0, 0, 0);
        chk_all("inc2", 4'b0010, 4'b0010, 4'b0001, 0);
        step(0, 1, INC, 0, 0, 0, 0);
        chk_all("inc3", 4'b0011, 4'b0001, 0, 0);
        step(1, 1, INC, 0, 0, 0, 0);
        chk_all("rst_mid", 4'b1010, 0, 0, 0);
        step(0, 1, INC, 0, 0, 0, 0);
        chk_all("inc_after", 4'b1011, 4'b0001, 0, 0);

        step(0, 1, SHL, 0, 0, 0, 1);
        chk_all("shl_b", 4'b0111, 4'b0100, 4'b1000, 1);
        step(1, 1, SHL, 0, 0, 0, 1);
        chk_all("rst_shl", 4'b1010, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
